// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Exports fwd_sel_e: operand select codes used by the execute-stage muxes.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one execute-stage source operand.
// Ports: rs_E (source tag), rd_M/reg_write_M, rd_W/reg_write_W, fwd (2-bit select).
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_E,
  input  logic [REG_ADDR_WIDTH-1:0] rd_M,
  input  logic                      reg_write_M,
  input  logic [REG_ADDR_WIDTH-1:0] rd_W,
  input  logic                      reg_write_W,
  output logic [1:0]                fwd
);

  logic hit_m;
  logic hit_w;
  logic hit_w_only;

  assign hit_m = reg_write_M
              && (rd_M != '0)
              && (rd_M == rs_E);

  assign hit_w = reg_write_W
              && (rd_W != '0)
              && (rd_W == rs_E);

  // Younger result in M shadows an older one in W.
  assign hit_w_only = hit_w && !hit_m;

  always_comb begin
    fwd = FWD_RF;
    unique case (1'b1)
      hit_m:      fwd = FWD_MEM;
      hit_w_only: fwd = FWD_WB;
      default:    fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: E/M/W tag shadows, forwarding selects, stall/flush, perf counters.
// Ports: i_clk/i_rst, Decode tags, i_pc_src_E, i_dmem_busy_M -> fwd selects, stalls, flushes, counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_D,
  input  logic                      i_use_rs1_D,
  input  logic                      i_use_rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_D,
  input  logic                      i_reg_write_D,
  input  logic                      i_is_load_D,
  input  logic                      i_pc_src_E,
  input  logic                      i_dmem_busy_M,
  output logic [1:0]                o_forward_rs1_EX,
  output logic [1:0]                o_forward_rs2_EX,
  output logic                      o_stall_F,
  output logic                      o_stall_D,
  output logic                      o_stall_E,
  output logic                      o_stall_M,
  output logic                      o_flush_D,
  output logic                      o_flush_E,
  output logic                      o_flush_W,
  output logic [CNT_WIDTH-1:0]      o_stall_cnt,
  output logic [CNT_WIDTH-1:0]      o_flush_cnt
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      is_load;
  } sh_e_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
  } sh_mw_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  sh_e_t  e_q;
  sh_e_t  e_d;
  sh_mw_t m_q;
  sh_mw_t w_q;

  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  logic rs1_dep;
  logic rs2_dep;
  logic lw_stall;
  logic lw_hold;
  logic mem_stall;
  logic stall_fd;
  logic stall_em;
  logic flush_d;
  logic flush_e;
  logic flush_w;

  // Unused sources are zeroed so they can never match a producer.
  always_comb begin
    e_d           = '0;
    e_d.rs1       = i_use_rs1_D ? i_rs1_D : '0;
    e_d.rs2       = i_use_rs2_D ? i_rs2_D : '0;
    e_d.rd        = i_rd_D;
    e_d.reg_write = i_reg_write_D;
    e_d.is_load   = i_is_load_D;
  end

  assign rs1_dep = i_use_rs1_D && (e_q.rd == i_rs1_D);
  assign rs2_dep = i_use_rs2_D && (e_q.rd == i_rs2_D);

  assign lw_stall = e_q.is_load
                 && (e_q.rd != '0)
                 && (rs1_dep || rs2_dep);

  assign mem_stall = i_dmem_busy_M;

  // A taken branch discards the dependent Decode instruction.
  assign lw_hold = lw_stall && !i_pc_src_E;

  assign stall_fd = lw_hold || mem_stall;
  assign stall_em = mem_stall;
  assign flush_w  = mem_stall;

  // Memory wait freezes everything; the branch retries afterwards.
  assign flush_d = i_pc_src_E && !mem_stall;
  assign flush_e = (lw_hold || i_pc_src_E) && !mem_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (flush_e) begin
        e_q <= '0;
      end else if (!stall_em) begin
        e_q <= e_d;
      end
      if (!stall_em) begin
        m_q <= {e_q.rd, e_q.reg_write};
      end
      if (flush_w) begin
        w_q <= '0;
      end else begin
        w_q <= m_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fd && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (flush_d && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  hazard_fwd_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs_E       (e_q.rs1),
    .rd_M       (m_q.rd),
    .reg_write_M(m_q.reg_write),
    .rd_W       (w_q.rd),
    .reg_write_W(w_q.reg_write),
    .fwd        (o_forward_rs1_EX)
  );

  hazard_fwd_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs_E       (e_q.rs2),
    .rd_M       (m_q.rd),
    .reg_write_M(m_q.reg_write),
    .rd_W       (w_q.rd),
    .reg_write_W(w_q.reg_write),
    .fwd        (o_forward_rs2_EX)
  );

  assign o_stall_F   = stall_fd;
  assign o_stall_D   = stall_fd;
  assign o_stall_E   = stall_em;
  assign o_stall_M   = stall_em;
  assign o_flush_D   = flush_d;
  assign o_flush_E   = flush_e;
  assign o_flush_W   = flush_w;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule
